// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_pkg
// Description : Shared definitions for the ALU execute stage: ALU_Control
//               codes, stage state encoding and the per-entry flag struct.
//               Optional macro ALU_EXEC_OVF_EN adds a signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_stage_pkg;

  // ALU_Control codes as produced by the upstream ALU controller
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Occupancy of the main (M) and skid (S) entries
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // M invalid, S invalid
    ST_ONE   = 2'b01,  // M valid,   S invalid
    ST_FULL  = 2'b10   // M valid,   S valid
  } stage_state_e;

  // Status bits stored alongside each buffered result. The result field
  // itself depends on WIDTH, so the full entry is assembled in the stage.
  typedef struct packed {
`ifdef ALU_EXEC_OVF_EN
    logic overflow;
`endif
    logic zero;
  } alu_flags_t;

endpackage : alu_exec_stage_pkg
`default_nettype wire

// File: rtl/alu_exec_stage_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU: add / and / or / sub modulo 2^WIDTH with
//               zero detect on the truncated result. With ALU_EXEC_OVF_EN
//               defined it also flags two's-complement overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Carry and borrow fall off the top: both are plain WIDTH-bit operations
  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;

  // Operation select and flag generation from the truncated result
  always_comb begin
    result = sum;
    flags  = '0;
    unique case (alu_ctrl)
      ALU_ADD: result = sum;
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_SUB: result = diff;
      default: result = sum;
    endcase

    flags.zero = (result == '0);

`ifdef ALU_EXEC_OVF_EN
    // Signed overflow: operands agree (add) or disagree (sub) in sign and
    // the result sign differs from operand_a
    unique case (alu_ctrl)
      ALU_ADD: flags.overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                                (result[WIDTH-1]    != operand_a[WIDTH-1]);
      ALU_SUB: flags.overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                                (result[WIDTH-1]    != operand_a[WIDTH-1]);
      default: flags.overflow = 1'b0;
    endcase
`endif
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Registered ALU execute stage with valid/ready on both sides,
//               one-cycle latency and a 2-entry skid buffer so in_ready is a
//               flop output independent of out_ready.
//               Optional macro ALU_EXEC_OVF_EN adds the overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALU_Control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             overflow
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } entry_t;

  stage_state_e state_q, state_d;
  entry_t       m_q, m_d;         // main entry, drives the outputs
  entry_t       s_q, s_d;         // skid entry, absorbs one result under stall
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  entry_t       new_entry;
  logic         accept;
  logic         xfer_out;

  // Compute happens ahead of the buffer so every entry is already final
  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .alu_ctrl  (ALU_Control),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (new_entry.result),
    .flags     (new_entry.flags)
  );

  assign accept   = in_valid    & in_ready_q;
  assign xfer_out = out_valid_q & out_ready;

  // Next-state and entry movement; handshake flags follow the next state
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer_out) begin
          m_d = new_entry;
        end else if (accept) begin
          s_d     = new_entry;
          state_d = ST_FULL;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready_q is low here, so accept cannot occur
        if (xfer_out) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State, storage and handshake registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = m_q.result;
  assign zero      = m_q.flags.zero;
`ifdef ALU_EXEC_OVF_EN
  assign overflow  = m_q.flags.overflow;
`endif

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench for alu_exec_stage (WIDTH=32). Covers the
//               overflow output when ALU_EXEC_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ALU_Control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_EXEC_OVF_EN
  logic             overflow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_Control (ALU_Control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero)
`ifdef ALU_EXEC_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  task automatic drive(input logic v, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid    = v;
    ALU_Control = c;
    operand_a   = a;
    operand_b   = b;
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a - b;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL reset_zero got %b want 0", zero); end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'd5, 32'd7);
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
    tests++; if (result !== 32'd12) begin fails++; $display("FAIL single_result got %0d want 12", result); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL single_zero got %b want 0", zero); end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_sub_zero();
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 32'h1234, 32'h1234);
    @(posedge clk); #1;
    tests++; if (result !== 32'd0 || out_valid !== 1'b1) begin fails++; $display("FAIL sub_result got %h v=%b want 0 v=1", result, out_valid); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL sub_zero got %b want 1", zero); end
    @(negedge clk);
    drive(1'b1, 2'b01, 32'hF0F0, 32'h0FF0);
    @(posedge clk); #1;
    tests++; if (result !== 32'h00F0) begin fails++; $display("FAIL and_result got %h want 000000f0", result); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL and_zero got %b want 0", zero); end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 32'd1, 32'd2);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd3, 32'd4);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
    @(negedge clk);
    drive(1'b1, 2'b11, 32'd10, 32'd1);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b1 || result !== 32'd3) begin fails++; $display("FAIL bp_first got %0d v=%b want 3 v=1", result, out_valid); end
    @(posedge clk); #1;
    tests++; if (result !== 32'd3 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold got %0d rdy=%b want 3 rdy=0", result, in_ready); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_second got %0d v=%b rdy=%b want 7 v=1 rdy=1", result, out_valid, in_ready); end
    @(posedge clk); #1;
    tests++; if (result !== 32'd9 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_third got %0d v=%b want 9 v=1", result, out_valid); end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup got v=%b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    logic [31:0] exp_r;
    logic [31:0] prev_res = '0;
    logic [31:0] a, b;
    logic [1:0]  c;
    logic        holding = 1'b0;
    logic        prev_stall = 1'b0;
    int          sent = 0;
    int          recv = 0;
    int          cycles = 0;
    exp_r = '0;
    while ((sent < 1000 || recv < sent) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || result !== prev_res) begin
          fails++; $display("FAIL stream_stall got %h v=%b want %h v=1", result, out_valid, prev_res);
        end
      end
      if (!holding) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          c = 2'($urandom_range(0, 3));
          a = $urandom;
          b = ($urandom_range(0, 7) == 0) ? a : $urandom;
          exp_r = ref_alu(c, a, b);
          drive(1'b1, c, a, b);
          holding = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL stream_extra got %h want none", result);
        end else if (result !== exp_q[0] || zero !== (exp_q[0] == 32'd0)) begin
          fails++; $display("FAIL stream_data got %h z=%b want %h", result, zero, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_r);
        sent++;
        holding = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end
    tests++;
    if (cycles >= 20000 || recv != 1000) begin
      fails++; $display("FAIL stream_count got %0d want 1000", recv);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd2, 32'd2);
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rf_full got rdy=%b want 0", in_ready); end
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin fails++; $display("FAIL rf_reset got v=%b rdy=%b r=%h want 0 1 0", out_valid, in_ready, result); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rf_discard got v=%b want 0", out_valid); end
  endtask

`ifdef ALU_EXEC_OVF_EN
  task automatic test_overflow();
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk); #1;
    tests++; if (overflow !== 1'b1 || result !== 32'h8000_0000) begin fails++; $display("FAIL ovf_add got o=%b r=%h want 1 80000000", overflow, result); end
    @(negedge clk);
    drive(1'b1, 2'b11, 32'h8000_0000, 32'd1);
    @(posedge clk); #1;
    tests++; if (overflow !== 1'b1 || result !== 32'h7FFF_FFFF) begin fails++; $display("FAIL ovf_sub got o=%b r=%h want 1 7fffffff", overflow, result); end
    @(negedge clk);
    drive(1'b1, 2'b10, 32'h7FFF_FFFF, 32'h8000_0000);
    @(posedge clk); #1;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_or got o=%b want 0", overflow); end
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd3, 32'd4);
    @(posedge clk); #1;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_add_small got o=%b want 0", overflow); end
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_sub_zero();
    test_backpressure();
    test_stream();
    test_reset_full();
`ifdef ALU_EXEC_OVF_EN
    test_overflow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_exec_stage
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of the ALU controller; consumes its 2-bit ALU_Control code plus two operands and produces result and zero flag.
- Valid/ready handshake on both sides, one-cycle latency, 2-entry skid buffer so in_ready is a pure register output with no combinational path from out_ready.
- Sits between register-read/operand select and write-back/branch compare.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and ALU_Control valid this cycle.
- in_ready  out  1  stage accepts input this cycle.
- ALU_Control  in  2  00 add, 01 and, 10 or, 11 sub.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand.
- out_valid  out  1  result/zero valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: out_valid=0, in_ready=1, result=0, zero=0, both buffer entries invalid. Reset mid-transfer discards all buffered data with no output.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Compute is combinational on the input side: add a+b, and a&b, or a|b, sub a-b. All modulo 2^WIDTH, carry/borrow discarded. zero is computed from the WIDTH-bit result and stored with it.
- Latency: an accepted input appears on result/zero with out_valid=1 on the next cycle.
- Storage: main entry M drives the outputs; skid entry S.
  - State EMPTY: M invalid, S invalid, in_ready=1. Accept → ONE.
  - State ONE: M valid, S invalid, in_ready=1.
    - Accept with no output transfer → M kept, new data to S → FULL.
    - Accept with output transfer → new data to M, stay ONE.
    - Output transfer with no accept → EMPTY.
  - State FULL: M and S valid, in_ready=0.
    - Output transfer → S moves to M → ONE.
    - in_valid is ignored while in FULL.
- in_ready is registered: it depends only on state, never on out_ready in the same cycle.
- Outputs must hold stable while out_valid=1 and out_ready=0.
- Full throughput: back-to-back accept with continuous out_ready gives one result per cycle in ONE.
- in_valid with in_ready=0 has no effect. Upstream must hold its data; this stage does not check that.

Optional Feature:
- Macro: ALU_EXEC_OVF_EN.
- Defined: adds output port overflow (1 bit), stored and moved with the result.
  - add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - and/or: 0.
  - Resets to 0.
- Undefined: port and storage absent. Behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - ALU_Control code constants (ALU_ADD=2'b00, ALU_AND=2'b01, ALU_OR=2'b10, ALU_SUB=2'b11).
  - Stage state encoding (EMPTY, ONE, FULL).
  - Result-entry struct (result, zero, optional overflow).
- One sub-module: alu_core, the combinational op and zero computation (plus overflow under the macro), instantiated once ahead of the buffer.

Test Plan:
- Reset held 2 cycles, then released → out_valid=0, in_ready=1, result=0, zero=0.
- Single op: ALU_Control=00, a=5, b=7, out_ready=1 → next cycle result=12, zero=0, out_valid=1.
- Subtract to zero: ALU_Control=11, a=0x1234, b=0x1234 → result=0, zero=1. Then and: a=0xF0F0, b=0x0FF0 → result=0x00F0.
- Backpressure: out_ready=0, send 3 ops (or 1|2, add 3+4, sub 10-1) → first two accepted, in_ready=0 after the second. Raise out_ready → results 3, 7 in order, then the third is accepted and yields 9. No loss or duplication.
- Streaming with random out_ready toggling over 1000 ops → output sequence equals a reference model, and result stays stable while stalled.
- ALU_EXEC_OVF_EN defined, WIDTH=32: add 0x7FFFFFFF+1 → overflow=1. Sub 0x80000000-1 → overflow=1. Or → overflow=0. Reset asserted with FULL state → next cycle out_valid=0, in_ready=1.
